huffman_packer: RTL and testbench

Downstream stage of the Huffman code builder. Latches the six-entry code table (HC1–HC6 codes, M1–M6 length masks) on `code_valid`, then encodes a stream of gray-level symbols (1–6) into their variable-length codes. Codes are packed MSB-first into 8-bit output words under a ready/valid handshake. A flush request emits the final partial word zero-padded, together with its valid-bit count.

---
 rtl/huffman_packer_if.sv | 36 +++
 rtl/huffman_packer.sv | 79 +++++++
 tb/tb_huffman_packer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/huffman_packer_if.sv
// huffman_packer_if: code table, symbol stream and packed-word stream of huffman_packer.
// HUFF_PACK_STATS_EN adds the sym_cnt/bit_cnt statistics signals.
interface huffman_packer_if;
  logic code_valid;
  logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0] M1, M2, M3, M4, M5, M6;
  logic sym_valid, sym_ready, flush;
  logic [7:0] sym_data;
  logic out_valid, out_ready, out_last, done, err;
  logic [7:0] out_data;
  logic [3:0] out_bits;
`ifdef HUFF_PACK_STATS_EN
  logic [15:0] sym_cnt, bit_cnt;
  modport master (
    output code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    output sym_valid, sym_data, flush, out_ready,
    input sym_ready, out_valid, out_data, out_last, out_bits, done, err, sym_cnt, bit_cnt
  );
  modport slave (
    input code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    input sym_valid, sym_data, flush, out_ready,
    output sym_ready, out_valid, out_data, out_last, out_bits, done, err, sym_cnt, bit_cnt
  );
`else
  modport master (
    output code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    output sym_valid, sym_data, flush, out_ready,
    input sym_ready, out_valid, out_data, out_last, out_bits, done, err
  );
  modport slave (
    input code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    input sym_valid, sym_data, flush, out_ready,
    output sym_ready, out_valid, out_data, out_last, out_bits, done, err
  );
`endif
endinterface

// File: rtl/huffman_packer.sv
// huffman_packer: encodes symbols 1-6 through a latched Huffman table, packing codes MSB-first into 8-bit words.
// Define HUFF_PACK_STATS_EN for saturating sym_cnt/bit_cnt statistics outputs.
module huffman_packer (
  input logic clk,
  input logic reset,
  huffman_packer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
  logic [1:0] state, nxt_state;
  logic [7:0] hc [1:6];
  logic [7:0] m [1:6];
  logic [6:0] code_tab [8];
  logic [3:0] len_tab [8];
  logic [14:0] acc, nxt_acc;
  logic [3:0] acc_cnt, nxt_cnt, len, sh;
  logic [6:0] code;
  logic legal, accept, push, pop, load;
  assign hc = '{bus.HC1, bus.HC2, bus.HC3, bus.HC4, bus.HC5, bus.HC6};
  assign m = '{bus.M1, bus.M2, bus.M3, bus.M4, bus.M5, bus.M6};
  assign legal = bus.sym_data != 8'd0 && bus.sym_data < 8'd7;
  assign code = code_tab[bus.sym_data[2:0]];
  assign len = len_tab[bus.sym_data[2:0]];
  // acc is left-aligned, so a new code lands just below the acc_cnt bits already held
  assign sh = 4'd15 - acc_cnt - len;
  assign accept = bus.sym_valid && bus.sym_ready;
  assign push = accept && legal;
  assign pop = bus.out_valid && bus.out_ready;
  assign load = bus.code_valid && (state == IDLE || (state == RUN && acc_cnt == 4'd0));
  assign bus.sym_ready = state == RUN && !acc_cnt[3];
  assign bus.out_valid = (state == RUN && acc_cnt[3]) || (state == FLUSH && acc_cnt != 4'd0);
  assign bus.out_last = state == FLUSH && !acc_cnt[3] && acc_cnt != 4'd0;
  assign bus.out_data = acc[14:7];
  assign bus.out_bits = !bus.out_valid ? 4'd0 : acc_cnt[3] ? 4'd8 : acc_cnt;
  assign bus.done = state == DONE;
  always_comb begin
    nxt_cnt = push ? acc_cnt + len : pop ? (acc_cnt[3] ? acc_cnt - 4'd8 : 4'd0) : acc_cnt;
    nxt_acc = state == DONE ? '0 : push ? acc | ({8'd0, code} << sh) : pop ? acc << 8 : acc;
    nxt_state = state == IDLE ? (bus.code_valid ? RUN : IDLE) :
                state == RUN ? (bus.flush ? (nxt_cnt == 4'd0 ? DONE : FLUSH) : RUN) :
                state == FLUSH ? (nxt_cnt == 4'd0 ? DONE : FLUSH) : RUN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      acc <= '0;
      acc_cnt <= '0;
      bus.err <= 1'b0;
    end else begin
      state <= nxt_state;
      acc <= nxt_acc;
      acc_cnt <= nxt_cnt;
      if (accept && !legal) bus.err <= 1'b1;
    end
  // entries 0 and 7 stay zero so illegal symbols index harmlessly
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        code_tab[i] <= '0;
        len_tab[i] <= '0;
      end
    end else if (load) begin
      for (int i = 1; i < 7; i++) begin
        code_tab[i] <= 7'(hc[i] & m[i]);
        len_tab[i] <= 4'($countones(m[i]));
      end
    end
`ifdef HUFF_PACK_STATS_EN
  logic [16:0] bit_sum;
  assign bit_sum = {1'b0, bus.bit_cnt} + {13'd0, len};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.sym_cnt <= '0;
      bus.bit_cnt <= '0;
    end else if (push) begin
      bus.sym_cnt <= bus.sym_cnt + {15'd0, ~&bus.sym_cnt};
      bus.bit_cnt <= bit_sum[16] ? 16'hFFFF : bit_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_huffman_packer.sv
// tb_huffman_packer: directed self-checking bench for huffman_packer.
module tb_huffman_packer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] wq[$];
  logic [3:0] bq[$];
  logic lq[$];
  huffman_packer_if bus();
  huffman_packer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (bus.out_valid && bus.out_ready) begin
      wq.push_back(bus.out_data);
      bq.push_back(bus.out_bits);
      lq.push_back(bus.out_last);
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_q;
    wq.delete();
    bq.delete();
    lq.delete();
  endtask
  task automatic load_table;
    bus.HC1 = 8'h01; bus.M1 = 8'h01;
    bus.HC2 = 8'h01; bus.M2 = 8'h03;
    bus.HC3 = 8'h00; bus.M3 = 8'h07;
    bus.HC4 = 8'h03; bus.M4 = 8'h0F;
    bus.HC5 = 8'h05; bus.M5 = 8'h1F;
    bus.HC6 = 8'h04; bus.M6 = 8'h1F;
    bus.code_valid = 1'b1;
    tick;
    bus.code_valid = 1'b0;
  endtask
  task automatic send(input logic [7:0] s);
    int n = 0;
    bus.sym_valid = 1'b1;
    bus.sym_data = s;
    while (!bus.sym_ready && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (bus.sym_ready !== 1'b1) begin errors++; $display("FAIL send_timeout sym %0d ready got %b exp 1", s, bus.sym_ready); end
    tick;
    bus.sym_valid = 1'b0;
  endtask
  task automatic flush_pulse;
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++; if (bus.sym_ready !== 1'b0) begin errors++; $display("FAIL reset_sym_ready got %b exp 0", bus.sym_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
    checks++; if (bus.out_bits !== 4'd0) begin errors++; $display("FAIL reset_out_bits got %0d exp 0", bus.out_bits); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
    tick;
    tick;
    reset = 1'b1;
    tick;
    tick;
    checks++; if (bus.sym_ready !== 1'b0) begin errors++; $display("FAIL idle_sym_ready got %b exp 0", bus.sym_ready); end
  endtask
  task automatic test_load;
    load_table;
    checks++; if (bus.sym_ready !== 1'b1) begin errors++; $display("FAIL load_sym_ready got %b exp 1", bus.sym_ready); end
  endtask
  task automatic test_ones;
    int c0;
    clear_q;
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(8'd1);
    checks++; if (cyc - c0 !== 8) begin errors++; $display("FAIL ones_throughput got %0d cycles exp 8", cyc - c0); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ones_out_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_data !== 8'hFF) begin errors++; $display("FAIL ones_out_data got %h exp ff", bus.out_data); end
    checks++; if (bus.out_bits !== 4'd8) begin errors++; $display("FAIL ones_out_bits got %0d exp 8", bus.out_bits); end
    checks++; if (bus.sym_ready !== 1'b0) begin errors++; $display("FAIL ones_sym_ready got %b exp 0", bus.sym_ready); end
    tick;
    flush_pulse;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ones_done got %b exp 1", bus.done); end
    tick;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ones_done_pulse got %b exp 0", bus.done); end
    checks++; if (bus.sym_ready !== 1'b1) begin errors++; $display("FAIL ones_rerun_ready got %b exp 1", bus.sym_ready); end
    checks++; if (wq.size() !== 1) begin errors++; $display("FAIL ones_word_count got %0d exp 1", wq.size()); end
    else if (wq[0] !== 8'hFF || bq[0] !== 4'd8 || lq[0] !== 1'b0) begin errors++; $display("FAIL ones_word got %h/%0d/%b exp ff/8/0", wq[0], bq[0], lq[0]); end
  endtask
  task automatic test_mix;
    clear_q;
    send(8'd2);
    send(8'd3);
    send(8'd4);
    flush_pulse;
    checks++; if (bus.out_last !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL mix_last got v%b l%b exp v1 l1", bus.out_valid, bus.out_last); end
    checks++; if (bus.out_data !== 8'h80 || bus.out_bits !== 4'd1) begin errors++; $display("FAIL mix_partial got %h/%0d exp 80/1", bus.out_data, bus.out_bits); end
    tick;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL mix_done got %b exp 1", bus.done); end
    tick;
    checks++; if (wq.size() !== 2) begin errors++; $display("FAIL mix_word_count got %0d exp 2", wq.size()); end
    else if (wq[0] !== 8'h41 || bq[0] !== 4'd8 || lq[0] !== 1'b0 || wq[1] !== 8'h80 || bq[1] !== 4'd1 || lq[1] !== 1'b1)
      begin errors++; $display("FAIL mix_words got %h/%0d/%b %h/%0d/%b exp 41/8/0 80/1/1", wq[0], bq[0], lq[0], wq[1], bq[1], lq[1]); end
  endtask
  task automatic test_five_six;
    clear_q;
    send(8'd5);
    send(8'd6);
    flush_pulse;
    checks++; if (bus.out_data !== 8'h00 || bus.out_bits !== 4'd2 || bus.out_last !== 1'b1) begin errors++; $display("FAIL fs_partial got %h/%0d/%b exp 00/2/1", bus.out_data, bus.out_bits, bus.out_last); end
    tick;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL fs_done got %b exp 1", bus.done); end
    tick;
    checks++; if (wq.size() !== 2) begin errors++; $display("FAIL fs_word_count got %0d exp 2", wq.size()); end
    else if (wq[0] !== 8'h29 || bq[0] !== 4'd8 || wq[1] !== 8'h00 || bq[1] !== 4'd2 || lq[1] !== 1'b1)
      begin errors++; $display("FAIL fs_words got %h/%0d %h/%0d/%b exp 29/8 00/2/1", wq[0], bq[0], wq[1], bq[1], lq[1]); end
  endtask
  task automatic test_backpressure;
    clear_q;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'd1);
    bus.sym_valid = 1'b1;
    bus.sym_data = 8'd1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.sym_ready !== 1'b0) begin errors++; $display("FAIL bp_sym_ready cyc %0d got %b exp 0", i, bus.sym_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF || bus.out_bits !== 4'd8 || bus.out_last !== 1'b0)
        begin errors++; $display("FAIL bp_hold cyc %0d got v%b %h/%0d/%b exp v1 ff/8/0", i, bus.out_valid, bus.out_data, bus.out_bits, bus.out_last); end
      tick;
    end
    bus.sym_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_pop got %b exp 0", bus.out_valid); end
    checks++; if (wq.size() !== 1) begin errors++; $display("FAIL bp_pop_count got %0d exp 1", wq.size()); end
    flush_pulse;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", bus.done); end
    tick;
  endtask
  task automatic test_illegal;
    logic [7:0] seq [10] = '{8'd1, 8'd7, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    clear_q;
    for (int i = 0; i < 10; i++) send(seq[i]);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", bus.err); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF) begin errors++; $display("FAIL ill_word got v%b %h exp v1 ff", bus.out_valid, bus.out_data); end
    tick;
    flush_pulse;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ill_done got %b exp 1", bus.done); end
    tick;
    checks++; if (wq.size() !== 1) begin errors++; $display("FAIL ill_word_count got %0d exp 1", wq.size()); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ill_err_sticky got %b exp 1", bus.err); end
  endtask
  task automatic test_reset_flush;
    bus.out_ready = 1'b0;
    send(8'd2);
    send(8'd3);
    flush_pulse;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_data !== 8'h40 || bus.out_bits !== 4'd5)
      begin errors++; $display("FAIL rf_partial got v%b l%b %h/%0d exp v1 l1 40/5", bus.out_valid, bus.out_last, bus.out_data, bus.out_bits); end
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 8'h00 || bus.out_bits !== 4'd0)
      begin errors++; $display("FAIL rf_reset_out got v%b l%b %h/%0d exp v0 l0 00/0", bus.out_valid, bus.out_last, bus.out_data, bus.out_bits); end
    checks++; if (bus.sym_ready !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0)
      begin errors++; $display("FAIL rf_reset_ctl got r%b d%b e%b exp r0 d0 e0", bus.sym_ready, bus.done, bus.err); end
    tick;
    tick;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick;
    tick;
    checks++; if (bus.sym_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rf_idle got r%b v%b exp r0 v0", bus.sym_ready, bus.out_valid); end
    load_table;
    checks++; if (bus.sym_ready !== 1'b1) begin errors++; $display("FAIL rf_reload got %b exp 1", bus.sym_ready); end
  endtask
  initial begin
    bus.code_valid = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_data = 8'd0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    {bus.HC1, bus.HC2, bus.HC3, bus.HC4, bus.HC5, bus.HC6} = '0;
    {bus.M1, bus.M2, bus.M3, bus.M4, bus.M5, bus.M6} = '0;
    #3 reset = 1'b0;
    test_reset;
    test_load;
    test_ones;
    test_mix;
    test_five_six;
    test_backpressure;
    test_illegal;
    test_reset_flush;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
